valu_oprnd_fifo: RTL and testbench
==================================

// Module: valu_oprnd_fifo
// PURPOSE
//  Parametrised operand FIFO that buffers VALU source operands between
//  decode/issue and the vector ALU.
//  - Circular buffer with read/write pointers; no data shifting.
//  - valid/ready handshake on both sides.
//  - Simultaneous enqueue and dequeue in the same cycle.
//  - Full, empty, almost-full and occupancy status outputs.
//  - Synchronous flush; sticky overflow/underflow error flags.
//  - One instance per operand (A, B, C). Successor to the fixed 5x32 operand queue.
// PARAMETERS
//  WIDTH     32  operand width in bits
//  DEPTH     8   number of entries, >=2; need not be a power of 2
//  AF_LEVEL  6   almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//  CW        $clog2(DEPTH+1)  derived count width; not to be overridden
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous reset, active-high
//  flush       in   1      synchronous clear of all entries
//  in_valid    in   1      producer offers in_data
//  in_ready    out  1      FIFO can accept; equals !full
//  in_data     in   WIDTH  operand to enqueue
//  out_valid   out  1      head entry valid; equals !empty
//  out_ready   in   1      consumer takes the head entry
//  out_data    out  WIDTH  head entry (first-word-fall-through)
//  count       out  CW     current occupancy, 0..DEPTH
//  full        out  1      count == DEPTH
//  empty       out  1      count == 0
//  almost_full out  1      count >= AF_LEVEL
//  err_ovf     out  1      sticky: in_valid seen while full
//  err_udf     out  1      sticky: out_ready seen while empty
// BEHAVIOUR
//  - Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0, err_*=0, empty=1,
//    full=0, almost_full=0, in_ready=1, out_valid=0, out_data=0.
//    Storage is not cleared. out_data is forced to 0 whenever empty.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - push writes mem[wr_ptr]; wr_ptr advances. pop advances rd_ptr.
//    Pointers wrap from DEPTH-1 to 0 by explicit compare, not modulo-2^n.
//  - Occupancy update per cycle: push only: count+1; pop only: count-1;
//    both: count unchanged, both pointers advance.
//  - FWFT: out_data = mem[rd_ptr] combinationally.
//    Enqueue-to-out_valid latency is 1 cycle. No empty bypass:
//    a push into an empty FIFO is visible the next cycle.
//  - When full: in_ready=0 in that cycle, even if a pop is occurring.
//    No full pass-through.
//  - Status flags are derived from registered count; no comb path from
//    in_valid/out_ready to in_ready/out_valid.
//  - flush: highest priority over push/pop in the same cycle.
//    Pointers and count go to 0; err_* are preserved.
//  - Error flags: err_ovf sets on in_valid & full. err_udf sets on
//    out_ready & empty. Both clear only on rst. Rejected requests do
//    not change state.
//  - Reset mid-operation: all contents are discarded; the state above
//    holds immediately (asynchronous).
// STRUCTURE
//  - valu_pkg: VALU_WORD_W=32, VALU_OPQ_DEPTH=8 defaults, shared with
//    other VALU queues.
//  - Sub-module valu_wrap_ptr (DEPTH, inc -> ptr, wraps at DEPTH-1),
//    instantiated twice (read and write pointers).
//  - Storage is a reg array; no reset on the array.
// TESTING
//  1 Reset: assert rst mid-burst -> count=0, empty=1, in_ready=1,
//    out_valid=0, out_data=0 in the same cycle.
//  2 Fill: push 0x11..0x18 into DEPTH=8 -> full=1 after the 8th;
//    almost_full=1 from count=6; 9th in_valid -> err_ovf=1, count stays 8.
//  3 Order: drain 8 -> out_data 0x11..0x18 in order; empty=1;
//    an extra out_ready -> err_udf=1.
//  4 Simultaneous: at count=3, push and pop together for 20 cycles ->
//    count stays 3, data order preserved across pointer wrap.
//  5 Flush: count=5 with push+pop+flush in one cycle -> next cycle
//    count=0, empty=1, err_* unchanged.
//  6 Non-power-of-2: DEPTH=5, 12 push/pop pairs -> wrap 4->0 is correct,
//    no data loss; random push/pop checked against a scoreboard model.

Source files
------------

// File: rtl/valu_pkg.sv
// Shared VALU queue parameters and occupancy helpers.
// Used by the operand FIFOs and other VALU queues.
package valu_pkg;

    localparam int VALU_WORD_W    = 32;
    localparam int VALU_OPQ_DEPTH = 8;
    localparam int VALU_OPQ_AF    = 6;

    typedef enum logic [1:0] {
        OCC_HOLD,
        OCC_INC,
        OCC_DEC
    } occ_op_e;

    // A push together with a pop leaves the occupancy unchanged.
    function automatic occ_op_e occ_op(input logic push, input logic pop);
        occ_op_e op;
        op = OCC_HOLD;
        if (push && !pop)
            op = OCC_INC;
        else if (pop && !push)
            op = OCC_DEC;
        return op;
    endfunction

endpackage

// File: rtl/valu_wrap_ptr.sv
// Circular buffer pointer that wraps from DEPTH-1 back to 0.
// DEPTH need not be a power of two.
module valu_wrap_ptr #(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // Clear has priority; otherwise advance with explicit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end

endmodule

// File: rtl/valu_oprnd_fifo.sv
// VALU source operand FIFO, first-word-fall-through.
// One instance per operand between issue and the vector ALU.
module valu_oprnd_fifo
    import valu_pkg::*;
#(
    parameter int WIDTH    = VALU_WORD_W,
    parameter int DEPTH    = VALU_OPQ_DEPTH,
    parameter int AF_LEVEL = VALU_OPQ_AF,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             err_ovf,
    output logic             err_udf
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Status comes only from the registered count.
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(AF_LEVEL));
    assign in_ready    = !full;
    assign out_valid   = !empty;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign out_data = empty ? '0 : mem[rd_ptr];

    valu_wrap_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    valu_wrap_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Storage write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    // Occupancy tracking, flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (flush)
            count <= '0;
        else begin
            unique case (occ_op(push, pop))
                OCC_INC: count <= count + CW'(1);
                OCC_DEC: count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky protocol error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (in_valid && full)
                err_ovf <= 1'b1;
            if (out_ready && empty)
                err_udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_valu_oprnd_fifo.sv
// Directed and scoreboard bench for valu_oprnd_fifo.
// Covers DEPTH=8 (AF 6) and DEPTH=5 (AF 4) instances.
module tb_valu_oprnd_fifo;

    typedef struct {
        logic        iv;
        logic        rdy;
        logic        fl;
        logic [31:0] din;
        int          cnt;
        logic [31:0] dout;
        logic        full;
        logic        af;
        logic        ovf;
        logic        udf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
    logic [31:0] a_in_data = 0;
    logic        a_in_ready, a_out_valid, a_full, a_empty, a_af;
    logic        a_ovf, a_udf;
    logic [31:0] a_out_data;
    logic [3:0]  a_count;

    logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
    logic [31:0] b_in_data = 0;
    logic        b_in_ready, b_out_valid, b_full, b_empty, b_af;
    logic        b_ovf, b_udf;
    logic [31:0] b_out_data;
    logic [2:0]  b_count;

    valu_oprnd_fifo #(.WIDTH(32), .DEPTH(8), .AF_LEVEL(6)) dut8 (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .count(a_count), .full(a_full),
        .empty(a_empty), .almost_full(a_af),
        .err_ovf(a_ovf), .err_udf(a_udf)
    );

    valu_oprnd_fifo #(.WIDTH(32), .DEPTH(5), .AF_LEVEL(4)) dut5 (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .count(b_count), .full(b_full),
        .empty(b_empty), .almost_full(b_af),
        .err_ovf(b_ovf), .err_udf(b_udf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic rdy,
                                input logic fl, input logic [31:0] din,
                                input int cnt, input logic [31:0] dout,
                                input logic full, input logic af,
                                input logic ovf, input logic udf);
        vec_t v;
        v.iv = iv; v.rdy = rdy; v.fl = fl; v.din = din;
        v.cnt = cnt; v.dout = dout; v.full = full; v.af = af;
        v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic apply8(input vec_t v, input string tag);
        a_in_valid  = v.iv;
        a_out_ready = v.rdy;
        a_flush     = v.fl;
        a_in_data   = v.din;
        @(posedge clk);
        #1;
        chk({tag, ".count"}, 64'(a_count), 64'(v.cnt));
        chk({tag, ".out_data"}, 64'(a_out_data), 64'(v.dout));
        chk({tag, ".full"}, 64'(a_full), 64'(v.full));
        chk({tag, ".empty"}, 64'(a_empty), 64'(v.cnt == 0));
        chk({tag, ".almost_full"}, 64'(a_af), 64'(v.af));
        chk({tag, ".err_ovf"}, 64'(a_ovf), 64'(v.ovf));
        chk({tag, ".err_udf"}, 64'(a_udf), 64'(v.udf));
        chk({tag, ".in_ready"}, 64'(a_in_ready), 64'(!v.full));
        chk({tag, ".out_valid"}, 64'(a_out_valid), 64'(v.cnt != 0));
    endtask

    task automatic step5(input logic iv, input logic rdy,
                         input logic [31:0] din);
        b_in_valid  = iv;
        b_out_ready = rdy;
        b_in_data   = din;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    logic [31:0] q[$];
    logic m_ovf, m_udf;
    logic r_iv, r_rdy;
    logic [31:0] r_din;

    initial begin
        // reset state at power-up
        #1;
        chk("rst0.count", 64'(a_count), 64'd0);
        chk("rst0.empty", 64'(a_empty), 64'd1);
        chk("rst0.out_data", 64'(a_out_data), 64'd0);
        chk("rst0.in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // fill, overflow, drain in order, underflow
        tbl.push_back(mk(1,0,0,32'h11, 1,32'h11, 0,0,0,0));
        tbl.push_back(mk(1,0,0,32'h12, 2,32'h11, 0,0,0,0));
        tbl.push_back(mk(1,0,0,32'h13, 3,32'h11, 0,0,0,0));
        tbl.push_back(mk(1,0,0,32'h14, 4,32'h11, 0,0,0,0));
        tbl.push_back(mk(1,0,0,32'h15, 5,32'h11, 0,0,0,0));
        tbl.push_back(mk(1,0,0,32'h16, 6,32'h11, 0,1,0,0));
        tbl.push_back(mk(1,0,0,32'h17, 7,32'h11, 0,1,0,0));
        tbl.push_back(mk(1,0,0,32'h18, 8,32'h11, 1,1,0,0));
        tbl.push_back(mk(1,0,0,32'h99, 8,32'h11, 1,1,1,0));
        tbl.push_back(mk(0,1,0,32'h0,  7,32'h12, 0,1,1,0));
        tbl.push_back(mk(0,1,0,32'h0,  6,32'h13, 0,1,1,0));
        tbl.push_back(mk(0,1,0,32'h0,  5,32'h14, 0,0,1,0));
        tbl.push_back(mk(0,1,0,32'h0,  4,32'h15, 0,0,1,0));
        tbl.push_back(mk(0,1,0,32'h0,  3,32'h16, 0,0,1,0));
        tbl.push_back(mk(0,1,0,32'h0,  2,32'h17, 0,0,1,0));
        tbl.push_back(mk(0,1,0,32'h0,  1,32'h18, 0,0,1,0));
        tbl.push_back(mk(0,1,0,32'h0,  0,32'h0,  0,0,1,0));
        tbl.push_back(mk(0,1,0,32'h0,  0,32'h0,  0,0,1,1));
        for (int i = 0; i < tbl.size(); i++)
            apply8(tbl[i], $sformatf("tbl%0d", i));

        // simultaneous push/pop at count 3, across pointer wrap
        apply8(mk(1,0,0,32'h21, 1,32'h21, 0,0,1,1), "sim_f1");
        apply8(mk(1,0,0,32'h22, 2,32'h21, 0,0,1,1), "sim_f2");
        apply8(mk(1,0,0,32'h23, 3,32'h21, 0,0,1,1), "sim_f3");
        for (int i = 0; i < 20; i++)
            apply8(mk(1,1,0,32'h24 + i, 3,32'h22 + i, 0,0,1,1),
                   $sformatf("sim%0d", i));

        // flush beats push and pop; errors survive
        apply8(mk(1,0,0,32'h40, 4,32'h35, 0,0,1,1), "fl_p1");
        apply8(mk(1,0,0,32'h41, 5,32'h35, 0,0,1,1), "fl_p2");
        apply8(mk(1,1,1,32'h42, 0,32'h0,  0,0,1,1), "flush");
        apply8(mk(1,0,0,32'h43, 1,32'h43, 0,0,1,1), "fl_after");
        apply8(mk(0,0,0,32'h0,  1,32'h43, 0,0,1,1), "fl_hold");
        a_in_valid = 0;

        // DEPTH=5: paired push/pop through several wraps
        step5(1, 0, 32'h50);
        for (int i = 0; i < 12; i++) begin
            step5(1, 1, 32'h51 + i);
            chk($sformatf("d5pair%0d.count", i), 64'(b_count), 64'd1);
            chk($sformatf("d5pair%0d.data", i), 64'(b_out_data),
                64'(32'h51 + i));
        end
        step5(0, 1, 32'h0);
        chk("d5pair.empty", 64'(b_empty), 64'd1);

        // DEPTH=5: fill to full starting mid-buffer, then drain
        for (int i = 0; i < 5; i++)
            step5(1, 0, 32'h60 + i);
        chk("d5fill.full", 64'(b_full), 64'd1);
        chk("d5fill.almost_full", 64'(b_af), 64'd1);
        chk("d5fill.count", 64'(b_count), 64'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("d5drain%0d.data", i), 64'(b_out_data),
                64'(32'h60 + i));
            step5(0, 1, 32'h0);
        end
        chk("d5drain.empty", 64'(b_empty), 64'd1);
        chk("d5drain.err_ovf", 64'(b_ovf), 64'd0);
        chk("d5drain.err_udf", 64'(b_udf), 64'd0);

        // DEPTH=5: random traffic against a queue model
        m_ovf = 0;
        m_udf = 0;
        for (int i = 0; i < 300; i++) begin
            r_iv  = 1'($urandom_range(0, 1));
            r_rdy = 1'($urandom_range(0, 1));
            r_din = $urandom;
            if (r_iv && q.size() == 5)
                m_ovf = 1;
            if (r_rdy && q.size() == 0)
                m_udf = 1;
            begin
                logic do_push, do_pop;
                do_push = r_iv && (q.size() < 5);
                do_pop  = r_rdy && (q.size() > 0);
                if (do_pop)
                    void'(q.pop_front());
                if (do_push)
                    q.push_back(r_din);
            end
            step5(r_iv, r_rdy, r_din);
            chk($sformatf("rnd%0d.count", i), 64'(b_count), 64'(q.size()));
            chk($sformatf("rnd%0d.data", i), 64'(b_out_data),
                64'(q.size() != 0 ? q[0] : 32'h0));
            chk($sformatf("rnd%0d.af", i), 64'(b_af), 64'(q.size() >= 4));
            chk($sformatf("rnd%0d.ovf", i), 64'(b_ovf), 64'(m_ovf));
            chk($sformatf("rnd%0d.udf", i), 64'(b_udf), 64'(m_udf));
        end
        b_in_valid  = 0;
        b_out_ready = 0;

        // asynchronous reset in the middle of a burst
        apply8(mk(1,0,0,32'h70, 2,32'h43, 0,0,1,1), "burst1");
        apply8(mk(1,0,0,32'h71, 3,32'h43, 0,0,1,1), "burst2");
        #2 rst = 1'b1;
        #1;
        chk("arst.count", 64'(a_count), 64'd0);
        chk("arst.empty", 64'(a_empty), 64'd1);
        chk("arst.full", 64'(a_full), 64'd0);
        chk("arst.almost_full", 64'(a_af), 64'd0);
        chk("arst.in_ready", 64'(a_in_ready), 64'd1);
        chk("arst.out_valid", 64'(a_out_valid), 64'd0);
        chk("arst.out_data", 64'(a_out_data), 64'd0);
        chk("arst.err_ovf", 64'(a_ovf), 64'd0);
        chk("arst.err_udf", 64'(a_udf), 64'd0);
        chk("arst.d5_count", 64'(b_count), 64'd0);
        a_in_valid = 0;
        @(posedge clk);
        #3 rst = 1'b0;
        apply8(mk(0,0,0,32'h0, 0,32'h0, 0,0,0,0), "post_rst");
        apply8(mk(1,0,0,32'h80, 1,32'h80, 0,0,0,0), "post_push");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
